alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu.sv | 31 +++
 rtl/alu_cmd_fifo.sv | 71 +++++++
 rtl/alu_cmd_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, legality check, command layout and sequencer state encoding
// Purpose: one place for the ALU opcode map so the sequencer and the ALU agree.
// Contents: OP_* opcode localparams, is_legal_op(), cmd_t (22-bit queued command), state_t.
package alu_pkg;

    localparam logic [4:0] OP_PASS_A = 5'b00000;
    localparam logic [4:0] OP_ADDC   = 5'b00001;
    localparam logic [4:0] OP_ADD    = 5'b00010;
    localparam logic [4:0] OP_PASS_B = 5'b00011;
    localparam logic [4:0] OP_AND    = 5'b00100;
    localparam logic [4:0] OP_OR     = 5'b00101;
    localparam logic [4:0] OP_XOR    = 5'b00110;
    localparam logic [4:0] OP_NOT_A  = 5'b00111;
    localparam logic [4:0] OP_SHL    = 5'b01000;
    localparam logic [4:0] OP_SHR    = 5'b10000;
    localparam logic [4:0] OP_ZERO   = 5'b11000;

    localparam int CMD_W = 22;

    typedef struct packed {
        logic [4:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    function automatic logic is_legal_op(input logic [4:0] sel);
        case (sel)
            OP_PASS_A, OP_ADDC, OP_ADD, OP_PASS_B, OP_AND, OP_OR,
            OP_XOR, OP_NOT_A, OP_SHL, OP_SHR, OP_ZERO: is_legal_op = 1'b1;
            default:                                   is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 8-bit ALU driven by the sequencer
// Ports: sel (opcode), a, b, carry_in operands; y result (illegal opcodes yield 0x00).
module alu
    import alu_pkg::*;
(
    input  logic [4:0] sel,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (sel)
            OP_PASS_A: y = a;
            OP_ADDC:   y = a + b + {7'b0, carry_in};
            OP_ADD:    y = a + b;
            OP_PASS_B: y = b;
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NOT_A:  y = ~a;
            OP_SHL:    y = {a[6:0], 1'b0};
            OP_SHR:    y = {1'b0, a[7:1]};
            OP_ZERO:   y = 8'h00;
            default:   y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command queue between the host handshake and the sequencer FSM
// Ports: clk, rst_n (sync, active-low); s_tvalid/s_tready/s_tdata write side;
//        m_tvalid/m_tready/m_tdata read side (m_tdata is the current head, popped on handshake).
module alu_cmd_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    // Ready depends only on the registered count, so a pop on the same edge
    // never lets a write slip into a full queue.
    assign s_tready = (count_q != (AW+1)'(DEPTH));
    assign m_tvalid = (count_q != '0);
    assign m_tdata  = mem_q[rptr_q];
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = s_tdata;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is read while the count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues ALU commands, drives an external ALU and returns results
// Ports: clk, rst_n (sync, active-low); cmd_valid/cmd_ready + cmd_sel/a/b/cin command in;
//        alu_sel/a/b/cin registered ALU drive, alu_y ALU result in;
//        res_valid/res_ready + res_y/res_err result out; busy = queue non-empty or FSM active.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] cmd_sel,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_cin,
    output logic [4:0] alu_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    input  logic [7:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_y,
    output logic       res_err,
    output logic       busy
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      alu_sel_q, alu_sel_d;
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic            alu_cin_q, alu_cin_d;
    logic [7:0]      res_y_q, res_y_d;
    logic            res_err_q, res_err_d;

    logic            fifo_tvalid;
    logic            fifo_tready;
    logic [CMD_W-1:0] fifo_tdata;
    cmd_t            head;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (cmd_valid),
        .s_tready (cmd_ready),
        .s_tdata  ({cmd_sel, cmd_a, cmd_b, cmd_cin}),
        .m_tvalid (fifo_tvalid),
        .m_tready (fifo_tready),
        .m_tdata  (fifo_tdata)
    );

    assign head        = cmd_t'(fifo_tdata);
    // The FSM consumes a command only while idle; the head is popped on that edge.
    assign fifo_tready = (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_sel_d = alu_sel_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        res_y_d   = res_y_q;
        res_err_d = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_tvalid) begin
                    if (is_legal_op(head.sel)) begin
                        alu_sel_d = head.sel;
                        alu_a_d   = head.a;
                        alu_b_d   = head.b;
                        alu_cin_d = head.cin;
                        cnt_d     = CW'(ALU_LAT - 1);
                        state_d   = ST_DRIVE;
                    end else begin
                        // Illegal opcode: answer immediately, leave the ALU drive untouched.
                        res_y_d   = 8'h00;
                        res_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_CAPTURE: begin
                res_y_d   = alu_y;
                res_err_d = 1'b0;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            alu_sel_q <= OP_ZERO;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
            alu_cin_q <= 1'b0;
            res_y_q   <= 8'h00;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_sel_q <= alu_sel_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            res_y_q   <= res_y_d;
            res_err_q <= res_err_d;
        end
    end

    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign res_y     = res_y_q;
    assign res_err   = res_err_q;
    assign res_valid = (state_q == ST_RESP);
    assign busy      = fifo_tvalid || (state_q != ST_IDLE);

endmodule
